// File: rtl/motor_pkg.sv
// Shared steering-bus definitions: DIR command codes and drive FSM states.
package motor_pkg;

  localparam logic [3:0] DIR_PROCEED      = 4'b0000;
  localparam logic [3:0] DIR_VEER_LEFT    = 4'b0101;
  localparam logic [3:0] DIR_HARD_LEFT    = 4'b0110;
  localparam logic [3:0] DIR_NINETY_LEFT  = 4'b0111;
  localparam logic [3:0] DIR_VEER_RIGHT   = 4'b1001;
  localparam logic [3:0] DIR_HARD_RIGHT   = 4'b1010;
  localparam logic [3:0] DIR_NINETY_RIGHT = 4'b1011;
  localparam logic [3:0] DIR_STOP         = 4'b1111;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PIVOT = 2'd2;

  // True for every code the direction controller is allowed to emit.
  function automatic logic dir_defined(input logic [3:0] code);
    case (code)
      DIR_PROCEED, DIR_VEER_LEFT, DIR_HARD_LEFT, DIR_NINETY_LEFT,
      DIR_VEER_RIGHT, DIR_HARD_RIGHT, DIR_NINETY_RIGHT, DIR_STOP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/motor_drive_if.sv
// Steering command bus in, H-bridge drive pins out.
interface motor_drive_if;
  logic       enable;
  logic [3:0] dir;
  logic       direction;
  logic       left_pwm;
  logic       right_pwm;
  logic       left_fwd;
  logic       right_fwd;
  logic       turning;

  modport master (
    output enable, dir, direction,
    input  left_pwm, right_pwm, left_fwd, right_fwd, turning
  );

  modport slave (
    input  enable, dir, direction,
    output left_pwm, right_pwm, left_fwd, right_fwd, turning
  );
endinterface

// File: rtl/pwm_channel.sv
// One H-bridge channel: slew-limited duty, polarity interlock, PWM compare.
module pwm_channel #(
  parameter int unsigned DUTY_W    = 10,
  parameter int unsigned RAMP_STEP = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] cnt,
  input  logic              bnd,
  input  logic              force_zero,
  input  logic [DUTY_W-1:0] tgt_duty,
  input  logic              tgt_pol,
  output logic              pwm,
  output logic              pol
);

  localparam logic [DUTY_W-1:0] STEP = DUTY_W'(RAMP_STEP);

  logic [DUTY_W-1:0] duty_cur;
  logic              pol_cur;
  logic [DUTY_W-1:0] eff_tgt;

  // Move toward tgt by at most STEP, landing exactly on tgt; never wraps.
  function automatic logic [DUTY_W-1:0] ramp_to(input logic [DUTY_W-1:0] cur,
                                                input logic [DUTY_W-1:0] tgt);
    if (cur < tgt) return ((tgt - cur) > STEP) ? cur + STEP : tgt;
    if (cur > tgt) return ((cur - tgt) > STEP) ? cur - STEP : tgt;
    return cur;
  endfunction

  // A pending polarity change first drains the duty to zero.
  always_comb begin
    eff_tgt = (tgt_pol != pol_cur) ? '0 : tgt_duty;
  end

  // Duty/polarity update: forced zero at once, otherwise only at period boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_cur <= '0;
      pol_cur  <= 1'b1;
    end else if (force_zero) begin
      duty_cur <= '0;
    end else if (bnd) begin
      if ((tgt_pol != pol_cur) && (duty_cur == '0)) pol_cur <= tgt_pol;
      else duty_cur <= ramp_to(duty_cur, eff_tgt);
    end
  end

  assign pwm = (cnt < duty_cur);
  assign pol = pol_cur;

endmodule

// File: rtl/motor_drive.sv
// Steering-bus consumer: DIR decode, pivot FSM and two slew-limited H-bridge channels.
module motor_drive
  import motor_pkg::*;
#(
  parameter int unsigned PWM_PERIOD  = 1000,
  parameter int unsigned VEER_DUTY   = 600,
  parameter int unsigned TURN_DUTY   = 800,
  parameter int unsigned TURN_CYCLES = 25_000_000,
  parameter int unsigned RAMP_STEP   = 50
) (
  input logic          clk,
  input logic          rst_n,
  motor_drive_if.slave bus
);

  localparam int unsigned DUTY_W = $clog2(PWM_PERIOD + 1);
  localparam int unsigned TMR_W  = $clog2(TURN_CYCLES + 1);

  localparam logic [DUTY_W-1:0] FULL     = DUTY_W'(PWM_PERIOD);
  localparam logic [DUTY_W-1:0] VEER     = DUTY_W'(VEER_DUTY);
  localparam logic [DUTY_W-1:0] TURN     = DUTY_W'(TURN_DUTY);
  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_PERIOD - 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TURN_CYCLES);

  logic [3:0]        dir_p0;
  logic              direction_p0;
  logic              enable_p0;

  logic [DUTY_W-1:0] cnt;
  logic              bnd;

  state_t            state, state_nxt;
  logic              side, side_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;

  logic [DUTY_W-1:0] l_duty, r_duty;
  logic              l_fwd, r_fwd;
  logic [DUTY_W-1:0] tgt_l_duty_p1, tgt_r_duty_p1;
  logic              tgt_l_pol_p1, tgt_r_pol_p1;

  logic              stop_cmd;
  logic              force_zero;
  logic              l_pwm, r_pwm, l_pol, r_pol;

  // Stage 0: register the command bus once on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_p0       <= DIR_PROCEED;
      direction_p0 <= 1'b1;
      enable_p0    <= 1'b0;
    end else begin
      dir_p0       <= bus.dir;
      direction_p0 <= bus.direction;
      enable_p0    <= bus.enable;
    end
  end

  // Shared PWM period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                      cnt <= cnt + DUTY_W'(1);
  end

  assign bnd      = (cnt == CNT_LAST);
  assign stop_cmd = (dir_p0 == DIR_STOP);

  // STOP, disable and undefined codes bypass the ramp; a pivot ignores undefined codes.
  assign force_zero = !enable_p0 || stop_cmd ||
                      ((state != ST_PIVOT) && !dir_defined(dir_p0));

  // Next-state, pivot side and pivot timer.
  always_comb begin
    state_nxt = state;
    side_nxt  = side;
    timer_nxt = timer;
    case (state)
      ST_IDLE: begin
        if (enable_p0) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!enable_p0) begin
          state_nxt = ST_IDLE;
        end else if ((dir_p0 == DIR_NINETY_LEFT) || (dir_p0 == DIR_NINETY_RIGHT)) begin
          state_nxt = ST_PIVOT;
          side_nxt  = (dir_p0 == DIR_NINETY_RIGHT);
          timer_nxt = TMR_LOAD;
        end
      end
      ST_PIVOT: begin
        if (timer != '0) timer_nxt = timer - TMR_W'(1);
        if (!enable_p0)               state_nxt = ST_IDLE;
        else if (stop_cmd)            state_nxt = ST_RUN;
        else if (timer <= TMR_W'(1))  state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Per-wheel targets for the state being entered; side 0 = left is the inner wheel.
  always_comb begin
    l_duty = '0;
    r_duty = '0;
    l_fwd  = 1'b1;
    r_fwd  = 1'b1;
    if (state_nxt == ST_PIVOT) begin
      l_duty = TURN;
      r_duty = TURN;
      l_fwd  = side_nxt;
      r_fwd  = !side_nxt;
    end else if (state_nxt == ST_RUN) begin
      case (dir_p0)
        DIR_PROCEED:    begin l_duty = FULL; r_duty = FULL; end
        DIR_VEER_LEFT:  begin l_duty = VEER; r_duty = FULL; end
        DIR_HARD_LEFT:  begin l_duty = '0;   r_duty = FULL; end
        DIR_VEER_RIGHT: begin l_duty = FULL; r_duty = VEER; end
        DIR_HARD_RIGHT: begin l_duty = FULL; r_duty = '0;   end
        default:        begin l_duty = '0;   r_duty = '0;   end
      endcase
    end
  end

  // Stage 1: FSM state and physical-polarity targets (reverse travel inverts both wheels).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      side          <= 1'b0;
      timer         <= '0;
      tgt_l_duty_p1 <= '0;
      tgt_r_duty_p1 <= '0;
      tgt_l_pol_p1  <= 1'b1;
      tgt_r_pol_p1  <= 1'b1;
    end else begin
      state         <= state_nxt;
      side          <= side_nxt;
      timer         <= timer_nxt;
      tgt_l_duty_p1 <= l_duty;
      tgt_r_duty_p1 <= r_duty;
      tgt_l_pol_p1  <= l_fwd ^ ~direction_p0;
      tgt_r_pol_p1  <= r_fwd ^ ~direction_p0;
    end
  end

  pwm_channel #(.DUTY_W(DUTY_W), .RAMP_STEP(RAMP_STEP)) u_left (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt        (cnt),
    .bnd        (bnd),
    .force_zero (force_zero),
    .tgt_duty   (tgt_l_duty_p1),
    .tgt_pol    (tgt_l_pol_p1),
    .pwm        (l_pwm),
    .pol        (l_pol)
  );

  pwm_channel #(.DUTY_W(DUTY_W), .RAMP_STEP(RAMP_STEP)) u_right (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt        (cnt),
    .bnd        (bnd),
    .force_zero (force_zero),
    .tgt_duty   (tgt_r_duty_p1),
    .tgt_pol    (tgt_r_pol_p1),
    .pwm        (r_pwm),
    .pol        (r_pol)
  );

  assign bus.left_pwm  = l_pwm;
  assign bus.right_pwm = r_pwm;
  assign bus.left_fwd  = l_pol;
  assign bus.right_fwd = r_pol;
  assign bus.turning   = (state == ST_PIVOT);

endmodule

// File: tb/tb_motor_drive.sv
// Scoreboard bench for motor_drive with PWM_PERIOD=10, RAMP_STEP=5, TURN_CYCLES=100.
module tb_motor_drive;
  import motor_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  motor_drive_if bus();

  motor_drive #(
    .PWM_PERIOD (10),
    .VEER_DUTY  (6),
    .TURN_DUTY  (8),
    .TURN_CYCLES(100),
    .RAMP_STEP  (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Expected outputs {left_pwm, right_pwm, left_fwd, right_fwd, turning} at a cycle.
  typedef struct {
    int         cyc;
    logic [4:0] vec;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t ent;
  int   cyc;
  int   total = 0;
  int   bad   = 0;

  logic [4:0] obs;
  logic       prev_ok = 1'b0;
  logic       prev_lf, prev_rf, prev_lp, prev_rp;

  // Cycle index = posedges since reset release; the DUT counter equals cyc mod 10.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc = 0;
    else        cyc = cyc + 1;
  end

  task automatic expect_at(input int c, input logic [4:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.vec  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic at_cyc(input int c);
    while (cyc != c) @(negedge clk);
  endtask

  // Monitor: pop due expectations, and check pwm is low around every polarity change.
  always @(negedge clk) begin
    if (rst_n) begin
      obs = {bus.left_pwm, bus.right_pwm, bus.left_fwd, bus.right_fwd, bus.turning};
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        ent = sb.pop_front();
        total++;
        if (ent.cyc != cyc || obs !== ent.vec) begin
          bad++;
          $display("FAIL %s @cyc %0d: got lp,rp,lf,rf,turn=%b required=%b (seen at cyc %0d)",
                   ent.name, ent.cyc, obs, ent.vec, cyc);
        end
      end
      if (prev_ok && (bus.left_fwd !== prev_lf)) begin
        total++;
        if (bus.left_pwm !== 1'b0 || prev_lp !== 1'b0) begin
          bad++;
          $display("FAIL left_interlock @cyc %0d: pwm before/after=%b%b required=00",
                   cyc, prev_lp, bus.left_pwm);
        end
      end
      if (prev_ok && (bus.right_fwd !== prev_rf)) begin
        total++;
        if (bus.right_pwm !== 1'b0 || prev_rp !== 1'b0) begin
          bad++;
          $display("FAIL right_interlock @cyc %0d: pwm before/after=%b%b required=00",
                   cyc, prev_rp, bus.right_pwm);
        end
      end
      prev_ok = 1'b1;
      prev_lf = bus.left_fwd;
      prev_rf = bus.right_fwd;
      prev_lp = bus.left_pwm;
      prev_rp = bus.right_pwm;
    end else begin
      prev_ok = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, pending=%0d", sb.size());
    $fatal(1);
  end

  initial begin
    bus.enable    = 1'b0;
    bus.dir       = DIR_PROCEED;
    bus.direction = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Ramp-up from reset, veer, pivot, STOP abort, reversal, undefined, disable.
    expect_at(0,   5'b00110, "reset_vals");
    expect_at(5,   5'b00110, "ramp_duty0");
    expect_at(12,  5'b11110, "ramp_duty5_hi");
    expect_at(17,  5'b00110, "ramp_duty5_lo");
    expect_at(25,  5'b11110, "ramp_duty10");
    expect_at(39,  5'b11110, "full_before_veer");
    expect_at(45,  5'b11110, "veer_l6_hi");
    expect_at(46,  5'b01110, "veer_l6_lo");
    expect_at(49,  5'b01110, "veer_r_full");
    expect_at(56,  5'b01110, "veer_hold");
    expect_at(66,  5'b11110, "back_to_full");
    expect_at(72,  5'b11110, "pre_pivot");
    expect_at(73,  5'b11111, "turning_rise");
    expect_at(84,  5'b11111, "pivot_l5_r8_hi");
    expect_at(85,  5'b01111, "pivot_l5_lo");
    expect_at(88,  5'b00111, "pivot_r8_lo");
    expect_at(95,  5'b01111, "pivot_l0");
    expect_at(99,  5'b00111, "pivot_before_flip");
    expect_at(100, 5'b01011, "pivot_left_flip");
    expect_at(114, 5'b11011, "pivot_rev5_hi");
    expect_at(115, 5'b01011, "pivot_rev5_lo");
    expect_at(118, 5'b00011, "pivot_r8_hold");
    expect_at(127, 5'b11011, "pivot_rev8_hi");
    expect_at(128, 5'b00011, "pivot_rev8_lo");
    expect_at(172, 5'b11011, "turning_last");
    expect_at(173, 5'b11010, "turning_fall");
    expect_at(182, 5'b11010, "unpivot_l3_hi");
    expect_at(183, 5'b01010, "unpivot_l3_lo");
    expect_at(199, 5'b01010, "unpivot_l0");
    expect_at(200, 5'b01110, "unpivot_flip");
    expect_at(214, 5'b11110, "unpivot_l5_hi");
    expect_at(215, 5'b01110, "unpivot_l5_lo");
    expect_at(229, 5'b11110, "unpivot_full");
    expect_at(233, 5'b11111, "pivot2_rise");
    expect_at(242, 5'b11111, "stop_not_yet");
    expect_at(243, 5'b00110, "stop_forced");
    expect_at(249, 5'b00110, "stop_hold");
    expect_at(264, 5'b11110, "resume_5_hi");
    expect_at(265, 5'b00110, "resume_5_lo");
    expect_at(279, 5'b11110, "resume_full");
    expect_at(294, 5'b11110, "rev_5_hi");
    expect_at(295, 5'b00110, "rev_5_lo");
    expect_at(305, 5'b00110, "rev_0");
    expect_at(309, 5'b00110, "rev_before_flip");
    expect_at(310, 5'b00000, "rev_flip");
    expect_at(324, 5'b11000, "rev_up5_hi");
    expect_at(325, 5'b00000, "rev_up5_lo");
    expect_at(339, 5'b11000, "rev_full");
    expect_at(342, 5'b11000, "undef_not_yet");
    expect_at(343, 5'b00000, "undef_forced");
    expect_at(364, 5'b11000, "undef_recover_hi");
    expect_at(365, 5'b00000, "undef_recover_lo");
    expect_at(372, 5'b11000, "disable_not_yet");
    expect_at(373, 5'b00000, "disable_forced");
    expect_at(383, 5'b00000, "idle_to_run");
    expect_at(384, 5'b00001, "pivot3_rise");
    expect_at(389, 5'b00001, "pivot3_hold");

    bus.enable = 1'b1;
    bus.dir    = DIR_PROCEED;
    rst_n      = 1'b1;

    at_cyc(31);  bus.dir = DIR_VEER_LEFT;
    at_cyc(51);  bus.dir = DIR_PROCEED;
    at_cyc(71);  bus.dir = DIR_NINETY_LEFT;
    at_cyc(81);  bus.dir = DIR_HARD_RIGHT;
    at_cyc(151); bus.dir = DIR_PROCEED;
    at_cyc(231); bus.dir = DIR_NINETY_LEFT;
    at_cyc(241); bus.dir = DIR_STOP;
    at_cyc(251); bus.dir = DIR_PROCEED;
    at_cyc(281); bus.direction = 1'b0;
    at_cyc(341); bus.dir = 4'b0001;
    at_cyc(351); bus.dir = DIR_PROCEED;
    at_cyc(371); bus.enable = 1'b0;
    at_cyc(381); begin bus.enable = 1'b1; bus.dir = DIR_NINETY_LEFT; end
    at_cyc(390); rst_n = 1'b0;

    // Reset mid-pivot, then restart in reverse: interlock flips polarity before ramping.
    bus.dir = DIR_PROCEED;
    repeat (3) @(posedge clk);
    #1;
    expect_at(0,  5'b00110, "reset2_vals");
    expect_at(9,  5'b00110, "reset2_pre_flip");
    expect_at(10, 5'b00000, "reset2_flip");
    expect_at(24, 5'b11000, "reset2_5_hi");
    expect_at(25, 5'b00000, "reset2_5_lo");
    expect_at(35, 5'b11000, "reset2_full");
    rst_n = 1'b1;

    at_cyc(40);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor_drive.md
# motor_drive

Consumer end of the 4-bit steering command bus produced by the line-following direction controller. Decodes each DIR code into per-wheel duty and polarity targets, then drives two H-bridge channels with slew-limited PWM and a polarity interlock. Executes 90-degree pivots as timed, non-interruptible manoeuvres, except by STOP or disable. Sits between the direction controller and the motor driver pins.

## Interface
- PWM_PERIOD, 1000: PWM period in clk cycles (50 kHz at 50 MHz).
- VEER_DUTY, 600: inner-wheel duty for VEER codes.
- TURN_DUTY, 800: duty of both wheels during a pivot.
- TURN_CYCLES, 25_000_000: pivot duration in clk cycles.
- RAMP_STEP, 50: maximum duty change per PWM period.
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  motors allowed; low forces both duties to 0.
- dir  in  4  steering command: [3:2] = 00 proceed, 01 left, 10 right, 11 stop; [1:0] = 01 veer, 10 hard, 11 ninety.
- direction  in  1  1 = forward travel, 0 = reverse; inverts both polarity outputs.
- left_pwm, right_pwm  out  1 each  PWM enables.
- left_fwd, right_fwd  out  1 each  H-bridge polarity, 1 = wheel turns forward.
- turning  out  1  high while a pivot is in progress.

## Operation
- dir, direction and enable are registered once on input. Decode uses the registered values.
- Decode to targets (duty, wheel-forward):
  - PROCEED 0000: both wheels PWM_PERIOD, forward.
  - VEER_LEFT 0101: left VEER_DUTY, right PWM_PERIOD.
  - HARD_LEFT 0110: left 0, right PWM_PERIOD.
  - Right-hand codes mirror the left-hand ones.
  - STOP 1111, and every undefined code: both wheels 0.
- Output polarity: fwd_out = wheel_fwd XOR ~direction.
- FSM states: IDLE, RUN, PIVOT.
  - IDLE: entered on reset or when enable is low. Leaves for RUN when enable is high.
  - RUN: continuous decode. NINETY_LEFT (0111) or NINETY_RIGHT (1011) enters PIVOT, latches the side and loads the timer with TURN_CYCLES.
  - PIVOT: inner wheel reverse at TURN_DUTY, outer wheel forward at TURN_DUTY. dir is ignored except STOP, which aborts to RUN. enable low aborts to IDLE. Timer reaching 0 returns to RUN. turning = 1 only in PIVOT.
- Each channel keeps duty_cur and pol_cur.
  - At every period boundary (cnt == PWM_PERIOD-1), duty_cur moves toward its target by at most RAMP_STEP and lands exactly on the target (no overshoot).
  - Polarity interlock: if target polarity differs from pol_cur, the effective target is 0. pol_cur flips at the first boundary where duty_cur == 0; the ramp up starts from the following boundary.
  - STOP, enable low, or an undefined code forces duty_cur to 0 on the next clock, without ramping. pol_cur is held.
- PWM output: pwm = (cnt < duty_cur).
  - duty 0 gives a constant low output.
  - duty PWM_PERIOD gives a constant high output.
- Arithmetic: duty width $clog2(PWM_PERIOD+1). Ramp subtraction saturates at 0; addition saturates at the target.

## Timing
- Reset values: pwm outputs 0, fwd outputs 1, turning 0, duty_cur 0, cnt 0, state IDLE.
- Shared counter cnt counts 0..PWM_PERIOD-1 and wraps.
- The dir input register adds 1 cycle. State and target update on the next cycle.
- duty_cur changes only at a period boundary, except forced zero.
- Forced-zero latency: pwm is low 2 cycles after STOP or enable-low appears on the inputs.
- Pivot timer decrements every cycle in PIVOT. turning falls on the cycle the timer hits 0.
- A full polarity reversal from PROCEED takes ceil(PWM_PERIOD/RAMP_STEP) periods to reach 0, plus 1 boundary for the flip.
- Reset mid-pivot or mid-ramp: immediate return to reset values.

## Structure
- Package motor_pkg holds:
  - the DIR code constants (PROCEED, VEER/HARD/NINETY_LEFT/RIGHT, STOP), shared with the direction controller;
  - the FSM state enum.
- Sub-module pwm_channel, instantiated twice, implements ramp, polarity interlock and compare. The top holds cnt, the FSM, the pivot timer and the decode.

## Test plan
Bench parameters: PWM_PERIOD=10, VEER_DUTY=6, TURN_DUTY=8, TURN_CYCLES=100, RAMP_STEP=5.
- Reset, enable=1, dir=0000 -> both duties step 0, 5, 10 at consecutive boundaries; pwm is constant high after that; fwd = 1.
- From PROCEED, dir=0101 -> left duty reaches 6 in 1 period (10 to 6, a step of 4); left pwm high for 6 of 10 cycles; right stays at 10.
- From PROCEED, dir=0111 -> turning rises. Left ramps 10, 5, 0, then left_fwd goes to 0, then left ramps 5, 8. Right ramps to 8. turning falls after exactly 100 cycles; dir changes during the pivot are ignored.
- During a pivot, dir=1111 -> turning falls within 2 cycles; both pwm outputs low within 2 cycles.
- From PROCEED, toggle direction to 0 -> both duties ramp to 0, then both fwd outputs go to 0, then both ramp back to 10. pwm is never high while fwd changes.
- dir=0001 (undefined) or enable=0 -> pwm low within 2 cycles; turning = 0.
